trigger_arm_ctrl: RTL and testbench

- Per-instrument arm/fire/re-arm controller sitting between the triggerer and downstream order logic.
- Owns each instrument's price window and sequences the triggerer's `rst_trigger` re-arm pulse.
- Applies the configured window-shift policy after each hit.
- Round-robin arbitrates simultaneous hits onto a single valid/ready fire stream.

---
 rtl/gg_fpga.sv | 37 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/trigger_arm_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trigger_arm_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gg_fpga.sv
// Shared types and price-window helpers for the trigger arm/fire path.
package gg_fpga;

   localparam int unsigned PRICE_W = 64;

   typedef enum logic {FIXED_WINDOW, HIT_WIDTH_SHIFT} trigger_mode_t;

   typedef enum logic [2:0] {DISARMED, ARMED, PENDING, REARM, COOLDOWN} slot_state_t;

   function automatic logic [2*PRICE_W-1:0] pack_window(input logic [PRICE_W-1:0] hi,
                                                        input logic [PRICE_W-1:0] lo);
      return {hi, lo};
   endfunction

   function automatic logic [PRICE_W-1:0] window_lo(input logic [2*PRICE_W-1:0] win);
      return win[PRICE_W-1:0];
   endfunction

   function automatic logic [PRICE_W-1:0] window_hi(input logic [2*PRICE_W-1:0] win);
      return win[2*PRICE_W-1:PRICE_W];
   endfunction

   // Recentre the window on the hit keeping its half-width; clamp at both ends of the range.
   function automatic logic [2*PRICE_W-1:0] shift_window(input logic [2*PRICE_W-1:0] win,
                                                         input logic [PRICE_W-1:0] hit);
      logic [PRICE_W-1:0] hw;
      logic [PRICE_W-1:0] new_lo;
      logic [PRICE_W-1:0] new_hi;
      logic [PRICE_W:0]   sum;
      hw     = (window_hi(win) - window_lo(win)) >> 1;
      new_lo = (hit < hw) ? '0 : hit - hw;
      sum    = {1'b0, hit} + {1'b0, hw};
      new_hi = sum[PRICE_W] ? '1 : sum[PRICE_W-1:0];
      return pack_window(new_hi, new_lo);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; pointer moves past the slot that was last granted.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   logic [IW-1:0] ptr_q, ptr_d;

   always_comb begin
      int unsigned j;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (en && !grant_valid && req[IW'(j)]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_valid) begin
         ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/trigger_arm_ctrl.sv
// Per-instrument arm/fire/re-arm sequencing with window policy and a round-robin fire stream.
module trigger_arm_ctrl
   import gg_fpga::*;
#(
   parameter int unsigned   NUM_INSTRUMENTS = 4,
   parameter int unsigned   COOLDOWN_CYCLES = 16,
   parameter trigger_mode_t TRIGGER_MODE    = FIXED_WINDOW,
   parameter logic [63:0]   DEF_PRICE_LO    = 64'd453600000000000,
   parameter logic [63:0]   DEF_PRICE_HI    = 64'd453650000000000,
   parameter bit            ARM_ON_RESET    = 1'b1,
   localparam int unsigned  IDXW = (NUM_INSTRUMENTS > 1) ? $clog2(NUM_INSTRUMENTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [IDXW-1:0]              cfg_idx,
   input  logic [63:0]                  cfg_price_lo,
   input  logic [63:0]                  cfg_price_hi,
   input  logic                         cfg_arm,
   input  logic [NUM_INSTRUMENTS-1:0]   fires,
   input  logic [63:0]                  md_price,
   output logic [NUM_INSTRUMENTS-1:0]   rst_trigger,
   output logic [NUM_INSTRUMENTS*128-1:0] price_triggers,
   output logic [NUM_INSTRUMENTS-1:0]   armed,
   output logic                         fire_valid,
   input  logic                         fire_ready,
   output logic [IDXW-1:0]              fire_idx,
   output logic [63:0]                  fire_price
);

   localparam int unsigned CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
   localparam int unsigned N  = NUM_INSTRUMENTS;

   slot_state_t    state_q [N];
   slot_state_t    state_d [N];
   logic [CW-1:0]  cnt_q   [N];
   logic [CW-1:0]  cnt_d   [N];
   logic [63:0]    hit_q   [N];
   logic [63:0]    hit_d   [N];
   logic [127:0]   win_q   [N];
   logic [127:0]   win_d   [N];

   logic            fire_valid_q, fire_valid_d;
   logic [IDXW-1:0] fire_idx_q, fire_idx_d;
   logic [63:0]     fire_price_q, fire_price_d;

   logic [N-1:0]    req;
   logic            out_free;
   logic            grant_valid;
   logic [IDXW-1:0] grant_idx;
   logic            cfg_hit;

   assign out_free = !fire_valid_q || fire_ready;
   assign cfg_hit  = cfg_we && (32'(cfg_idx) < N);

   always_comb begin
      req            = '0;
      rst_trigger    = '1;
      armed          = '0;
      price_triggers = '0;
      for (int unsigned i = 0; i < N; i++) begin
         req[i]                   = (state_q[i] == PENDING);
         rst_trigger[i]           = (state_q[i] != REARM);
         armed[i]                 = (state_q[i] == ARMED);
         price_triggers[i*128 +: 128] = win_q[i];
      end
   end

   rr_arbiter #(
      .N (N)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .en          (out_free),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      fire_valid_d = fire_valid_q;
      fire_idx_d   = fire_idx_q;
      fire_price_d = fire_price_q;
      if (grant_valid) begin
         fire_valid_d = 1'b1;
         fire_idx_d   = grant_idx;
         fire_price_d = hit_q[grant_idx];
      end else if (fire_ready) begin
         fire_valid_d = 1'b0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         hit_d[i]   = hit_q[i];
         win_d[i]   = win_q[i];
         unique case (state_q[i])
            ARMED: begin
               if (fires[i]) begin
                  state_d[i] = PENDING;
                  hit_d[i]   = md_price;
               end
            end
            PENDING: begin
               if (grant_valid && grant_idx == IDXW'(i)) begin
                  state_d[i] = REARM;
                  if (TRIGGER_MODE == HIT_WIDTH_SHIFT) win_d[i] = shift_window(win_q[i], hit_q[i]);
               end
            end
            REARM: begin
               if (COOLDOWN_CYCLES == 0) begin
                  state_d[i] = ARMED;
               end else begin
                  state_d[i] = COOLDOWN;
                  cnt_d[i]   = CW'(COOLDOWN_CYCLES);
               end
            end
            COOLDOWN: begin
               if (cnt_q[i] == CW'(1)) state_d[i] = ARMED;
               else                    cnt_d[i]   = cnt_q[i] - 1'b1;
            end
            default: ;
         endcase
         // Config overrides whatever the slot was doing, including a same-cycle grant.
         if (cfg_hit && cfg_idx == IDXW'(i)) begin
            state_d[i] = cfg_arm ? ARMED : DISARMED;
            cnt_d[i]   = '0;
            win_d[i]   = pack_window(cfg_price_hi, cfg_price_lo);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_valid_q <= 1'b0;
         fire_idx_q   <= '0;
         fire_price_q <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= ARM_ON_RESET ? ARMED : DISARMED;
            cnt_q[i]   <= '0;
            hit_q[i]   <= '0;
            win_q[i]   <= pack_window(DEF_PRICE_HI, DEF_PRICE_LO);
         end
      end else begin
         fire_valid_q <= fire_valid_d;
         fire_idx_q   <= fire_idx_d;
         fire_price_q <= fire_price_d;
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            hit_q[i]   <= hit_d[i];
            win_q[i]   <= win_d[i];
         end
      end
   end

   assign fire_valid = fire_valid_q;
   assign fire_idx   = fire_idx_q;
   assign fire_price = fire_price_q;

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Bench: scoreboarded fire stream on a fixed-window instance, table-driven window shifting.
module tb_trigger_arm_ctrl;
   import gg_fpga::*;

   localparam logic [63:0] DEF_LO = 64'd453600000000000;
   localparam logic [63:0] DEF_HI = 64'd453650000000000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         cfg_we = 1'b0, cfg_arm = 1'b0, fire_ready = 1'b1;
   logic [1:0]   cfg_idx = '0;
   logic [63:0]  cfg_price_lo = '0, cfg_price_hi = '0, md_price = '0;
   logic [3:0]   fires = '0;
   logic [3:0]   rst_trigger, armed;
   logic [511:0] price_triggers;
   logic         fire_valid;
   logic [1:0]   fire_idx;
   logic [63:0]  fire_price;

   logic         s_cfg_we = 1'b0, s_cfg_arm = 1'b0, s_fire_ready = 1'b1;
   logic [1:0]   s_cfg_idx = '0;
   logic [63:0]  s_cfg_price_lo = '0, s_cfg_price_hi = '0, s_md_price = '0;
   logic [3:0]   s_fires = '0;
   logic [3:0]   s_rst_trigger, s_armed;
   logic [511:0] s_price_triggers;
   logic         s_fire_valid;
   logic [1:0]   s_fire_idx;
   logic [63:0]  s_fire_price;

   trigger_arm_ctrl #(
      .NUM_INSTRUMENTS (4),
      .COOLDOWN_CYCLES (16),
      .TRIGGER_MODE    (FIXED_WINDOW),
      .DEF_PRICE_LO    (DEF_LO),
      .DEF_PRICE_HI    (DEF_HI),
      .ARM_ON_RESET    (1'b1)
   ) dut (
      .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_idx (cfg_idx),
      .cfg_price_lo (cfg_price_lo), .cfg_price_hi (cfg_price_hi), .cfg_arm (cfg_arm),
      .fires (fires), .md_price (md_price), .rst_trigger (rst_trigger),
      .price_triggers (price_triggers), .armed (armed), .fire_valid (fire_valid),
      .fire_ready (fire_ready), .fire_idx (fire_idx), .fire_price (fire_price)
   );

   trigger_arm_ctrl #(
      .NUM_INSTRUMENTS (4),
      .COOLDOWN_CYCLES (2),
      .TRIGGER_MODE    (HIT_WIDTH_SHIFT),
      .DEF_PRICE_LO    (DEF_LO),
      .DEF_PRICE_HI    (DEF_HI),
      .ARM_ON_RESET    (1'b1)
   ) dut_shift (
      .clk (clk), .rst (rst), .cfg_we (s_cfg_we), .cfg_idx (s_cfg_idx),
      .cfg_price_lo (s_cfg_price_lo), .cfg_price_hi (s_cfg_price_hi), .cfg_arm (s_cfg_arm),
      .fires (s_fires), .md_price (s_md_price), .rst_trigger (s_rst_trigger),
      .price_triggers (s_price_triggers), .armed (s_armed), .fire_valid (s_fire_valid),
      .fire_ready (s_fire_ready), .fire_idx (s_fire_idx), .fire_price (s_fire_price)
   );

   typedef struct {
      logic [1:0]  idx;
      logic [63:0] price;
   } rec_t;

   typedef struct {
      logic [63:0] lo;
      logic [63:0] hi;
      logic [63:0] hit;
      logic [63:0] exp_lo;
      logic [63:0] exp_hi;
   } vec_t;

   rec_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fires = '0; cfg_we = 1'b0; s_fires = '0; s_cfg_we = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Every accepted record must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && fire_valid && fire_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got idx=%0d price=%0d expected no record",
                     fire_idx, fire_price);
         end else begin
            rec_t r;
            r = sb_q.pop_front();
            if (fire_idx !== r.idx || fire_price !== r.price) begin
               errors++;
               $display("FAIL sb_record: got idx=%0d price=%0d expected idx=%0d price=%0d",
                        fire_idx, fire_price, r.idx, r.price);
            end
         end
      end
   end

   initial begin
      vec_t vecs[6];
      logic ok;
      logic [63:0] p;

      vecs[0] = '{lo: 64'd100, hi: 64'd200, hit: 64'd150, exp_lo: 64'd100, exp_hi: 64'd200};
      vecs[1] = '{lo: 64'd100, hi: 64'd200, hit: 64'd30, exp_lo: 64'd0, exp_hi: 64'd80};
      vecs[2] = '{lo: 64'd100, hi: 64'd200, hit: 64'hFFFF_FFFF_FFFF_FFF6,
                  exp_lo: 64'hFFFF_FFFF_FFFF_FFC4, exp_hi: 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{lo: 64'd0, hi: 64'd1000, hit: 64'd5000, exp_lo: 64'd4500, exp_hi: 64'd5500};
      vecs[4] = '{lo: 64'd10, hi: 64'd11, hit: 64'd7, exp_lo: 64'd7, exp_hi: 64'd7};
      vecs[5] = '{lo: 64'd300, hi: 64'd100, hit: 64'd1000,
                  exp_lo: 64'd0, exp_hi: 64'h8000_0000_0000_0384};

      // Reset state
      #2 rst = 1'b1;
      #1;
      check("rst_armed", 128'(armed), 128'(4'hF));
      check("rst_rst_trigger", 128'(rst_trigger), 128'(4'hF));
      check("rst_fire_valid", 128'(fire_valid), 128'(1'b0));
      check("rst_fire_idx_price", {62'd0, fire_idx, fire_price}, 128'd0);
      for (int i = 0; i < 4; i++)
         check($sformatf("rst_window%0d", i), price_triggers[i*128 +: 128], {DEF_HI, DEF_LO});
      tick(); tick();
      rst = 1'b0;

      // Single hit on slot 0: latency, re-arm pulse, 16-cycle blind period
      p = 64'd453620000000000;
      fire_ready = 1'b1; md_price = p; fires = 4'b0001;
      sb_q.push_back('{idx: 2'd0, price: p});
      tick();
      fires = '0;
      check("single_pending_armed", 128'(armed), 128'(4'b1110));
      tick();
      check("single_fire_valid", 128'(fire_valid), 128'(1'b1));
      check("single_rearm_pulse", 128'(rst_trigger), 128'(4'b1110));
      check("fixed_window_kept", price_triggers[127:0], {DEF_HI, DEF_LO});
      tick();
      check("single_rearm_released", 128'(rst_trigger), 128'(4'hF));
      ok = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (armed[0]) ok = 1'b0;
         tick();
      end
      check("cooldown_blind_16", 128'(ok), 128'(1'b1));
      check("cooldown_rearmed", 128'(armed), 128'(4'hF));

      // Simultaneous hits with a stalled consumer: RR order 0,1,3, record held stable
      do_reset();
      p = 64'd453610000000000;
      fire_ready = 1'b0; md_price = p; fires = 4'b1011;
      sb_q.push_back('{idx: 2'd0, price: p});
      sb_q.push_back('{idx: 2'd1, price: p});
      sb_q.push_back('{idx: 2'd3, price: p});
      tick();
      fires = '0;
      check("multi_pending_armed", 128'(armed), 128'(4'b0100));
      tick();
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (!fire_valid || fire_idx !== 2'd0 || fire_price !== p) ok = 1'b0;
         tick();
      end
      check("stall_record_stable", 128'(ok), 128'(1'b1));
      fire_ready = 1'b1;
      repeat (6) tick();
      check("multi_all_delivered", 128'(sb_q.size()), 128'd0);

      // Reset while a record is waiting discards it
      fire_ready = 1'b0; md_price = 64'd77; fires = 4'b1000;
      tick();
      fires = '0;
      tick();
      rst = 1'b1;
      #1;
      check("midreset_fire_valid", 128'(fire_valid), 128'(1'b0));
      check("midreset_armed", 128'(armed), 128'(4'hF));
      tick();
      rst = 1'b0;
      fire_ready = 1'b1;
      repeat (3) tick();

      // Hits on slot 2 while cooling down, then while disarmed
      p = 64'd453630000000000;
      md_price = p; fires = 4'b0100;
      sb_q.push_back('{idx: 2'd2, price: p});
      tick();
      fires = '0;
      tick(); tick();
      fires = 4'b0100;
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (rst_trigger !== 4'hF || fire_valid) ok = 1'b0;
      end
      check("cooldown_hits_ignored", 128'(ok), 128'(1'b1));
      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_arm = 1'b0;
      cfg_price_lo = 64'd1000; cfg_price_hi = 64'd2000;
      tick();
      cfg_we = 1'b0;
      check("disarm_armed", 128'(armed), 128'(4'b1011));
      check("disarm_window", price_triggers[2*128 +: 128], {64'd2000, 64'd1000});
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rst_trigger !== 4'hF || fire_valid || armed[2]) ok = 1'b0;
      end
      check("disarmed_hits_ignored", 128'(ok), 128'(1'b1));
      fires = '0;

      // Slot 1 pending behind a stalled record, dropped by a config write
      do_reset();
      fire_ready = 1'b0; md_price = 64'd111; fires = 4'b0001;
      sb_q.push_back('{idx: 2'd0, price: 64'd111});
      tick();
      md_price = 64'd222; fires = 4'b0010;
      tick();
      fires = '0;
      check("cfgdrop_pending_armed", 128'(armed), 128'(4'b1100));
      tick(); tick();
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_arm = 1'b1;
      cfg_price_lo = 64'd500; cfg_price_hi = 64'd600;
      tick();
      cfg_we = 1'b0;
      check("cfgdrop_slot1_armed", 128'(armed[1]), 128'(1'b1));
      check("cfgdrop_slot1_window", price_triggers[1*128 +: 128], {64'd600, 64'd500});
      fire_ready = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!rst_trigger[1]) ok = 1'b0;
      end
      check("cfgdrop_no_rearm_slot1", 128'(ok), 128'(1'b1));

      // Window shifting, table-driven on the HIT_WIDTH_SHIFT instance
      for (int i = 0; i < 6; i++) begin
         s_cfg_we = 1'b1; s_cfg_idx = 2'd0; s_cfg_arm = 1'b1;
         s_cfg_price_lo = vecs[i].lo; s_cfg_price_hi = vecs[i].hi;
         tick();
         s_cfg_we = 1'b0; s_fires = 4'b0001; s_md_price = vecs[i].hit;
         tick();
         s_fires = '0;
         tick();
         check($sformatf("shift_window_v%0d", i), s_price_triggers[127:0],
               {vecs[i].exp_hi, vecs[i].exp_lo});
         check($sformatf("shift_record_v%0d", i), {63'd0, s_fire_valid, s_fire_price},
               {63'd0, 1'b1, vecs[i].hit});
         repeat (4) tick();
      end

      check("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
